// File: rtl/display_pkg.sv
// Shared types and the active-low hex glyph table for the 7-segment scan driver.
package display_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } scan_state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Segment order {g,f,e,d,c,b,a}, 0 = lit; 'b' and 'd' are lowercase glyphs
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational nibble-to-glyph lookup; the caller registers the result.
module hex_to_7seg
    import display_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] seg_o
);

    assign seg_o = SEG_TABLE[nib_i];

endmodule

// File: rtl/display_scan_driver.sv
// Time-multiplexed common-anode 7-segment driver with a blanking gap between digits.
// Optional leading-zero suppression is enabled by defining SCAN_LZ_BLANK_EN.
module display_scan_driver
    import display_pkg::*;
#(
    parameter int N_DIGITS     = 4,
    parameter int BLANK_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    tick_i,
    input  logic                    en_i,
    input  logic [4*N_DIGITS-1:0]   value_i,
    input  logic [N_DIGITS-1:0]     dp_i,
    output logic [N_DIGITS-1:0]     an_o,
    output logic [6:0]              seg_o,
    output logic                    dp_o,
    output logic                    frame_o
);

    localparam int IW = $clog2(N_DIGITS);
    localparam int BW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;

    scan_state_t             state_q;
    logic [IW-1:0]           idx_q;
    logic [BW-1:0]           bcnt_q;
    logic [4*N_DIGITS-1:0]   snap_val_q;
    logic [N_DIGITS-1:0]     snap_dp_q;
    logic [N_DIGITS-1:0]     an_q;
    logic [6:0]              seg_q;
    logic                    dp_q;
    logic                    frame_q;

    logic [3:0]              nib_d;
    logic [6:0]              glyph_d;
    logic [6:0]              seg_d;
    logic [N_DIGITS-1:0]     an_d;
    logic                    dp_d;
    logic                    suppress_d;

    // Select the current digit's nibble, decimal point and anode pattern
    always_comb begin
        nib_d = 4'h0;
        dp_d  = 1'b1;
        an_d  = '1;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (IW'(i) == idx_q) begin
                nib_d   = snap_val_q[i*4 +: 4];
                dp_d    = ~snap_dp_q[i];
                an_d[i] = 1'b0;
            end else begin
                an_d[i] = 1'b1;
            end
        end
    end

    hex_to_7seg u_dec (
        .nib_i (nib_d),
        .seg_o (glyph_d)
    );

`ifdef SCAN_LZ_BLANK_EN
    logic hi_zero_s;

    // A digit is dark when it and every higher nibble are zero; digit 0 always shows
    always_comb begin
        hi_zero_s  = 1'b1;
        suppress_d = 1'b0;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            hi_zero_s  = hi_zero_s & (snap_val_q[i*4 +: 4] == 4'h0);
            suppress_d = ((IW'(i) == idx_q) && (i != 0)) ? hi_zero_s : suppress_d;
        end
    end
`else
    assign suppress_d = 1'b0;
`endif

    assign seg_d = suppress_d ? SEG_BLANK : glyph_d;

    // Scan FSM; all pin values are registered alongside the state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            bcnt_q     <= '0;
            snap_val_q <= '0;
            snap_dp_q  <= '0;
            an_q       <= '1;
            seg_q      <= SEG_BLANK;
            dp_q       <= 1'b1;
            frame_q    <= 1'b0;
        end else begin
            frame_q <= 1'b0;
            if (!en_i) begin
                state_q <= IDLE;
                idx_q   <= '0;
                bcnt_q  <= '0;
                an_q    <= '1;
                seg_q   <= SEG_BLANK;
                dp_q    <= 1'b1;
            end else begin
                case (state_q)
                    IDLE: begin
                        state_q    <= BLANK;
                        idx_q      <= '0;
                        bcnt_q     <= '0;
                        snap_val_q <= value_i;
                        snap_dp_q  <= dp_i;
                        an_q       <= '1;
                        seg_q      <= SEG_BLANK;
                        dp_q       <= 1'b1;
                    end
                    BLANK: begin
                        if (bcnt_q == BW'(BLANK_CYCLES - 1)) begin
                            state_q <= SHOW;
                            an_q    <= an_d;
                            seg_q   <= seg_d;
                            dp_q    <= dp_d;
                        end else begin
                            bcnt_q  <= bcnt_q + 1'b1;
                        end
                    end
                    SHOW: begin
                        if (tick_i) begin
                            state_q <= BLANK;
                            bcnt_q  <= '0;
                            an_q    <= '1;
                            seg_q   <= SEG_BLANK;
                            dp_q    <= 1'b1;
                            // Latch the next frame only at the wrap so a frame never mixes data
                            if (idx_q == IW'(N_DIGITS - 1)) begin
                                idx_q      <= '0;
                                frame_q    <= 1'b1;
                                snap_val_q <= value_i;
                                snap_dp_q  <= dp_i;
                            end else begin
                                idx_q      <= idx_q + 1'b1;
                            end
                        end else begin
                            state_q <= SHOW;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        an_q    <= '1;
                        seg_q   <= SEG_BLANK;
                        dp_q    <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign an_o    = an_q;
    assign seg_o   = seg_q;
    assign dp_o    = dp_q;
    assign frame_o = frame_q;

endmodule

// File: tb/tb_display_scan_driver.sv
// Directed self-checking bench for display_scan_driver (N_DIGITS=4, BLANK_CYCLES=4).
// Leading-zero expectations follow SCAN_LZ_BLANK_EN when it is defined.
module tb_display_scan_driver;

    logic        clk;
    logic        rst;
    logic        tick_i;
    logic        en_i;
    logic [15:0] value_i;
    logic [3:0]  dp_i;
    logic [3:0]  an_o;
    logic [6:0]  seg_o;
    logic        dp_o;
    logic        frame_o;

    int n_pass  = 0;
    int n_total = 0;

    display_scan_driver #(.N_DIGITS(4), .BLANK_CYCLES(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .tick_i  (tick_i),
        .en_i    (en_i),
        .value_i (value_i),
        .dp_i    (dp_i),
        .an_o    (an_o),
        .seg_o   (seg_o),
        .dp_o    (dp_o),
        .frame_o (frame_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk_dark(input string tag);
        chk({tag, "_an"},  32'(an_o),  32'h0000_000F);
        chk({tag, "_seg"}, 32'(seg_o), 32'h0000_007F);
        chk({tag, "_dp"},  32'(dp_o),  32'h0000_0001);
    endtask

    task automatic chk_lit(input string tag, input logic [3:0] e_an, input logic [6:0] e_seg,
                           input logic e_dp);
        chk({tag, "_an"},  32'(an_o),  32'(e_an));
        chk({tag, "_seg"}, 32'(seg_o), 32'(e_seg));
        chk({tag, "_dp"},  32'(dp_o),  32'(e_dp));
    endtask

    // From SHOW: strobe, 4 dark cycles (with an ignored strobe inside), then next digit lit
    task automatic next_digit(input string tag, input logic [3:0] e_an, input logic [6:0] e_seg,
                              input logic e_dp, input logic e_frame);
        tick_i = 1'b1;
        step();
        tick_i = 1'b0;
        chk_dark({tag, "_t1"});
        chk({tag, "_frame"}, 32'(frame_o), 32'(e_frame));
        tick_i = 1'b1;
        step();
        tick_i = 1'b0;
        chk({tag, "_t2_an"}, 32'(an_o), 32'h0000_000F);
        chk({tag, "_t2_frame"}, 32'(frame_o), 32'h0000_0000);
        step();
        step();
        chk({tag, "_t4_an"}, 32'(an_o), 32'h0000_000F);
        step();
        chk_lit(tag, e_an, e_seg, e_dp);
    endtask

    initial begin
        rst     = 1'b1;
        tick_i  = 1'b0;
        en_i    = 1'b0;
        value_i = 16'h0000;
        dp_i    = 4'b0000;
        step();
        chk_dark("reset");
        chk("reset_frame", 32'(frame_o), 32'h0000_0000);

        rst     = 1'b0;
        en_i    = 1'b1;
        value_i = 16'h12AF;
        dp_i    = 4'b0100;
        step();
        chk_dark("start_blank");
        step();
        step();
        step();
        chk({"start_t4_an"}, 32'(an_o), 32'h0000_000F);
        step();
        chk_lit("d0_F", 4'hE, 7'h0E, 1'b1);
        next_digit("d1_A", 4'hD, 7'h08, 1'b1, 1'b0);
        next_digit("d2_2", 4'hB, 7'h24, 1'b0, 1'b0);
        next_digit("d3_1", 4'h7, 7'h79, 1'b1, 1'b0);

        value_i = 16'h1111;
        dp_i    = 4'b0000;
        next_digit("f2_d0", 4'hE, 7'h79, 1'b1, 1'b1);
        value_i = 16'h2222;
        next_digit("f2_d1", 4'hD, 7'h79, 1'b1, 1'b0);
        next_digit("f2_d2", 4'hB, 7'h79, 1'b1, 1'b0);
        next_digit("f2_d3", 4'h7, 7'h79, 1'b1, 1'b0);
        next_digit("f3_d0", 4'hE, 7'h24, 1'b1, 1'b1);

        tick_i = 1'b1;
        en_i   = 1'b0;
        step();
        tick_i = 1'b0;
        chk_dark("en_drop");
        chk("en_drop_frame", 32'(frame_o), 32'h0000_0000);
        step();
        chk_dark("idle_hold");
        value_i = 16'h12AF;
        en_i    = 1'b1;
        step();
        chk_dark("restart_blank");
        step();
        step();
        step();
        step();
        chk_lit("restart_d0", 4'hE, 7'h0E, 1'b1);

        rst = 1'b1;
        #1;
        chk_dark("async_rst");
        chk("async_rst_frame", 32'(frame_o), 32'h0000_0000);
        step();
        rst     = 1'b0;
        value_i = 16'h0040;
        dp_i    = 4'b1000;
        step();
        step();
        step();
        step();
        step();
        chk_lit("lz_d0", 4'hE, 7'h40, 1'b1);
        next_digit("lz_d1", 4'hD, 7'h19, 1'b1, 1'b0);
`ifdef SCAN_LZ_BLANK_EN
        next_digit("lz_d2", 4'hB, 7'h7F, 1'b1, 1'b0);
        next_digit("lz_d3", 4'h7, 7'h7F, 1'b0, 1'b0);
`else
        next_digit("lz_d2", 4'hB, 7'h40, 1'b1, 1'b0);
        next_digit("lz_d3", 4'h7, 7'h40, 1'b0, 1'b0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
